// File: rtl/mmu_ctx_loader.sv
// MMU context loader: walks a 4*NMMU-entry map table in memory and writes each entry to the MMU as a select/map pair.
// Optional build macro MMU_CTX_SAVE_FAULT_EN restores the pre-load fault register after the last entry.
module mmu_ctx_loader #(
    parameter int RV   = 16,
    parameter int VA   = RV,
    parameter int NMMU = 8,
    parameter int AW   = RV
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [RV-1:0] mem_rdata,
    output logic          mmu_reg_write,
    output logic [RV-1:0] mmu_reg_data,
    input  logic [RV-1:0] mmu_reg_read
);

    localparam int PW = $clog2(NMMU);
    localparam int U  = VA - PW;
    localparam int I  = PW + 2;
    localparam logic [I-1:0] LAST = I'(4 * NMMU - 1);

`ifdef MMU_CTX_SAVE_FAULT_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEL, MAP, RESTORE, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEL, MAP, FIN} state_t;
`endif

    state_t         state_q, state_d;
    logic [I-1:0]   idx_q, idx_d;
    logic [AW-1:0]  base_q, base_d;
    logic [RV-1:1]  map_q, map_d;
    logic [RV-1:0]  data_q, data_d;
    logic           done_q, done_d;
    logic           wr;
    logic           req;
    logic [RV-1:0]  sel_w;

`ifdef MMU_CTX_SAVE_FAULT_EN
    logic [RV-1:1]  save_q;
    logic           unused_bits;
    assign unused_bits = mem_rdata[0] ^ mmu_reg_read[0];

    // Fault register snapshot taken on the same edge that accepts start
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            save_q <= mmu_reg_read[RV-1:1];
        end
    end
`else
    logic           unused_bits;
    assign unused_bits = mem_rdata[0] ^ (^mmu_reg_read);
`endif

    // Select word: page in the top bits, ins/sup flags in bits 4/3, valid bit0 clear
    always_comb begin
        sel_w          = '0;
        sel_w[VA-1:U]  = idx_q[PW-1:0];
        sel_w[4]       = idx_q[I-1];
        sel_w[3]       = idx_q[I-2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        map_q <= map_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        map_d   = map_q;
        data_d  = data_q;
        done_d  = 1'b0;
        wr      = 1'b0;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                req = 1'b1;
                if (mem_ack) begin
                    map_d   = mem_rdata[RV-1:1];
                    state_d = SEL;
                end
            end
            SEL: begin
                wr      = 1'b1;
                data_d  = sel_w;
                state_d = MAP;
            end
            MAP: begin
                wr     = 1'b1;
                data_d = {map_q, 1'b1};
                if (idx_q == LAST) begin
`ifdef MMU_CTX_SAVE_FAULT_EN
                    state_d = RESTORE;
`else
                    state_d = FIN;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
`ifdef MMU_CTX_SAVE_FAULT_EN
            RESTORE: begin
                wr      = 1'b1;
                data_d  = {save_q, 1'b0};
                state_d = FIN;
            end
`endif
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write data is driven combinationally in the write cycle and held afterwards
    assign mmu_reg_write = wr;
    assign mmu_reg_data  = data_d;
    assign mem_req       = req;
    assign mem_addr      = base_q + AW'(idx_q);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule
